seq_detect_ctrl: RTL and testbench

Programmable serial-pattern detection controller. It holds a run-time pattern (length 1..MAXLEN), arms detection on start, and qualifies the serial input w with w_valid. It counts matches in overlapping or non-overlapping mode and stops with done after a programmed number of matches. It replaces fixed-pattern detectors in the FSM block set, with software-style configure/start/abort control.

---
 rtl/seq_detect_pkg.sv | 24 ++
 rtl/seq_match_core.sv | 45 ++++
 rtl/seq_detect_ctrl.sv | 110 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types, default widths and length clamp for the sequence detector
package seq_detect_pkg;

   localparam int MAXLEN_D = 8;
   localparam int LENW_D   = 4;
   localparam int CNTW_D   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Zero length means a single-bit pattern; anything past maxlen is pinned to maxlen.
   function automatic int clamp_len(input int l, input int maxlen);
      if (l == 0)
         return 1;
      else if (l > maxlen)
         return maxlen;
      else
         return l;
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// rtl/seq_match_core.sv - history shift register, saturating fill counter and masked pattern compare
module seq_match_core
   import seq_detect_pkg::*;
#(
   parameter int MAXLEN = MAXLEN_D,
   parameter int LENW   = LENW_D
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift,
   input  logic              clear,
   input  logic              flush,
   input  logic              w,
   input  logic [LENW-1:0]   len,
   input  logic [MAXLEN-1:0] pattern,
   output logic              match
);

   logic [MAXLEN-1:0] history;
   logic [MAXLEN-1:0] hist_nx;
   logic [MAXLEN-1:0] mask;
   logic [LENW-1:0]   fill;
   logic [LENW-1:0]   fill_nx;

   // Match is judged on the post-shift view so z can be registered on the sampling edge.
   always_comb begin
      hist_nx = {history[MAXLEN-2:0], w};
      fill_nx = (fill >= len) ? fill : fill + LENW'(1);
      mask    = '0;
      for (int i = 0; i < MAXLEN; i++)
         mask[i] = (i < int'(len));
      match = shift && (fill_nx >= len) && (((hist_nx ^ pattern) & mask) == '0);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         history <= '0;
         fill    <= '0;
      end else if (shift) begin
         history <= hist_nx;
         fill    <= flush ? '0 : fill_nx;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector with start/abort control and match counting
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int MAXLEN = MAXLEN_D,
   parameter int LENW   = LENW_D,
   parameter int CNTW   = CNTW_D
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LENW-1:0]   cfg_len,
   input  logic [CNTW-1:0]   cfg_count,
   input  logic              cfg_overlap,
   input  logic              start,
   input  logic              abort,
   input  logic              w,
   input  logic              w_valid,
   output logic              z,
   output logic              busy,
   output logic              done,
   output logic [CNTW-1:0]   match_cnt
);

   state_t            state;
   state_t            state_nx;
   logic [MAXLEN-1:0] pat_q;
   logic [LENW-1:0]   len_q;
   logic [CNTW-1:0]   cnt_q;
   logic              ovl_q;
   logic              cfg_ok;
   logic              start_ok;
   logic              shift;
   logic              match;
   logic              hit_limit;
   logic [CNTW-1:0]   cnt_inc;

   assign cfg_ok    = (state != RUN);
   assign start_ok  = start && cfg_ok && !abort;
   assign shift     = (state == RUN) && w_valid && !abort;
   assign cnt_inc   = (match_cnt == '1) ? match_cnt : match_cnt + CNTW'(1);
   assign hit_limit = match && (cnt_q != '0) && (cnt_inc == cnt_q);

   seq_match_core #(
      .MAXLEN (MAXLEN),
      .LENW   (LENW)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .shift   (shift),
      .clear   (start_ok),
      .flush   (match && !ovl_q),
      .w       (w),
      .len     (len_q),
      .pattern (pat_q),
      .match   (match)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // abort outranks start and any match on the same edge
   always_comb begin
      state_nx = state;
      if (abort)
         state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (hit_limit) state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q     <= '0;
         len_q     <= LENW'(1);
         cnt_q     <= '0;
         ovl_q     <= 1'b0;
         match_cnt <= '0;
         z         <= 1'b0;
      end else begin
         if (cfg_we && cfg_ok) begin
            pat_q <= cfg_pattern;
            len_q <= LENW'(clamp_len(int'(cfg_len), MAXLEN));
            cnt_q <= cfg_count;
            ovl_q <= cfg_overlap;
         end
         if (start_ok)
            match_cnt <= '0;
         else if (match)
            match_cnt <= cnt_inc;
         z <= match;
      end
   end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - scoreboard bench for seq_detect_ctrl with directed serial streams
module tb_seq_detect_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic [7:0] cfg_count;
   logic       cfg_overlap;
   logic       start;
   logic       abort;
   logic       w;
   logic       w_valid;
   logic       z;
   logic       busy;
   logic       done;
   logic [7:0] match_cnt;

   typedef struct {
      int         cyc;
      logic [7:0] cnt;
      logic       dn;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   tests = 0;
   int   failed = 0;

   logic stream [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   seq_detect_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_count   (cfg_count),
      .cfg_overlap (cfg_overlap),
      .start       (start),
      .abort       (abort),
      .w           (w),
      .w_valid     (w_valid),
      .z           (z),
      .busy        (busy),
      .done        (done),
      .match_cnt   (match_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic config_set(input logic [7:0] p, input logic [3:0] l, input logic [7:0] c, input logic o);
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_count = c; cfg_overlap = o;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic send(input logic b, input logic m, input int c, input logic d);
      w = b;
      w_valid = 1'b1;
      if (m) sb.push_back('{cyc + 1, 8'(c), d});
      tick();
      w_valid = 1'b0;
   endtask

   task automatic gap();
      w_valid = 1'b0;
      w = ~w;
      tick();
   endtask

   task automatic drain(input string name);
      tick();
      tick();
      check({name, "_pending_z"}, sb.size(), 0);
      sb.delete();
   endtask

   // monitor: every z pulse must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (z === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_z_cycle", cyc, 0);
            end else begin
               e = sb.pop_front();
               check("z_cycle", cyc, e.cyc);
               check("z_match_cnt", match_cnt, e.cnt);
               check("z_done", done, e.dn);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_count = 0; cfg_overlap = 0;
      start = 0; abort = 0; w = 0; w_valid = 0;
      tick(); tick();
      reset = 1'b0;
      check("rst_z", z, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", match_cnt, 0);

      // overlapping, unlimited: matches after bits 5 and 8
      config_set(8'b1011, 4'd4, 8'd0, 1'b1);
      do_start();
      check("s1_busy", busy, 1);
      for (int i = 0; i < 11; i++)
         send(stream[i], (i == 4 || i == 7), (i == 4) ? 1 : 2, 1'b0);
      drain("s1");
      check("s1_cnt", match_cnt, 2);
      check("s1_busy_end", busy, 1);

      // non-overlapping: flush suppresses the bit-8 match
      do_abort();
      config_set(8'b1011, 4'd4, 8'd0, 1'b0);
      do_start();
      check("s2_cnt_clr", match_cnt, 0);
      for (int i = 0; i < 11; i++)
         send(stream[i], (i == 4), 1, 1'b0);
      drain("s2");
      check("s2_cnt", match_cnt, 1);

      // count limit 1: done with the first z, rest ignored
      do_abort();
      config_set(8'b1011, 4'd4, 8'd1, 1'b1);
      do_start();
      for (int i = 0; i < 11; i++)
         send(stream[i], (i == 4), 1, 1'b1);
      drain("s3");
      check("s3_busy", busy, 0);
      check("s3_done", done, 1);
      check("s3_cnt", match_cnt, 1);
      do_start();
      check("s3_restart_busy", busy, 1);
      check("s3_restart_done", done, 0);
      check("s3_restart_cnt", match_cnt, 0);

      // gaps are transparent; config writes in RUN are ignored
      do_abort();
      config_set(8'b1011, 4'd4, 8'd0, 1'b1);
      do_start();
      send(1, 0, 0, 0); gap();
      send(0, 0, 0, 0); gap(); gap();
      send(1, 0, 0, 0);
      send(1, 1, 1, 0);
      drain("s4a");
      config_set(8'b11, 4'd2, 8'd0, 1'b1);
      send(1, 0, 0, 0);
      send(0, 0, 0, 0);
      send(1, 0, 0, 0);
      send(1, 1, 2, 0);
      drain("s4b");
      check("s4_cnt", match_cnt, 2);

      // abort wins over start; count retained
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      check("s5_busy", busy, 0);
      check("s5_done", done, 0);
      check("s5_cnt", match_cnt, 2);
      @(negedge clk);
      check("s5_z", z, 0);
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      check("s5_rst_busy", busy, 0);
      check("s5_rst_cnt", match_cnt, 0);
      check("s5_rst_z", z, 0);

      // len 0 acts as a single-bit pattern
      config_set(8'h01, 4'd0, 8'd0, 1'b1);
      do_start();
      send(1, 1, 1, 0);
      send(1, 1, 2, 0);
      send(0, 0, 0, 0);
      send(1, 1, 3, 0);
      drain("s6");
      check("s6_cnt", match_cnt, 3);

      // len 15 clamps to 8: zero pattern first matches on the 8th zero
      do_abort();
      config_set(8'h00, 4'd15, 8'd0, 1'b1);
      do_start();
      for (int i = 0; i < 9; i++)
         send(0, (i >= 7), i - 6, 0);
      drain("s7");
      check("s7_cnt", match_cnt, 2);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
